// File: rtl/axi_rd_arb_if.sv
// Shared AXI read-channel signals seen by the round-robin grant controller.
// master: the arbiter (drives grants); slave: the masters/slave side feeding requests and handshakes.
interface axi_rd_arb_if #(
  parameter int NUM_M = 2
);
  logic [NUM_M-1:0] m_req;
  logic [NUM_M-1:0] m_grnt;
  logic             arvalid;
  logic             arready;
  logic [3:0]       arlen;
  logic             rvalid;
  logic             rready;
  logic             rlast;

  modport master (
    input  m_req, arvalid, arready, arlen, rvalid, rready, rlast,
    output m_grnt
  );

  modport slave (
    output m_req, arvalid, arready, arlen, rvalid, rready, rlast,
    input  m_grnt
  );
endinterface

// File: rtl/axi_rd_rr_arbiter.sv
// Round-robin AXI read grant holder: grant 1 cycle after request, held for one AR+R burst, 1 dead cycle after rlast.
// Never backpressures the channel; optional hung-slave watchdog enabled by AXI_RD_ARB_TIMEOUT_EN.
module axi_rd_rr_arbiter #(
  parameter int NUM_M       = 2,
  parameter int IDX_W       = 1,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  axi_rd_arb_if.master     bus,
  input  logic             i_err_clr,
  output logic             o_busy,
  output logic [IDX_W-1:0] o_owner,
  output logic             o_err_len,
  output logic             o_err_timeout
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ADDR = 2'd1, S_DATA = 2'd2} state_t;

  localparam int IDX_W_EXP = (NUM_M <= 2) ? 1 : $clog2(NUM_M);

  if ((NUM_M < 2) || (NUM_M > 8) || (IDX_W != IDX_W_EXP) || (TIMEOUT_CYC < 1)) begin : g_param_chk
    $error("axi_rd_rr_arbiter: illegal NUM_M/IDX_W/TIMEOUT_CYC combination");
  end

  state_t           r_state, w_state_nxt;
  logic [NUM_M-1:0] r_grnt, w_grnt_nxt;
  logic [IDX_W-1:0] r_owner, w_owner_nxt;
  logic [IDX_W-1:0] r_last, w_last_nxt;
  logic [3:0]       r_cnt, w_cnt_nxt;
  logic             r_err_len;
  logic             w_ar_hs, w_r_hs, w_len_err, w_to;
  logic             w_hi_found, w_lo_found, w_any;
  logic [IDX_W-1:0] w_hi, w_lo, w_win;

  assign w_ar_hs   = (r_state == S_ADDR) && bus.arvalid && bus.arready;
  assign w_r_hs    = (r_state == S_DATA) && bus.rvalid && bus.rready;
  assign w_len_err = w_r_hs && (bus.rlast ? (r_cnt != 4'd0) : (r_cnt == 4'd0));
  assign w_any     = |bus.m_req;

  // Lowest requester above the last winner, else lowest requester at or below it (wrap).
  always_comb begin
    w_hi_found = 1'b0;
    w_lo_found = 1'b0;
    w_hi       = '0;
    w_lo       = '0;
    for (int j = NUM_M - 1; j >= 0; j--) begin
      if (bus.m_req[j]) begin
        if (j > int'(r_last)) begin
          w_hi_found = 1'b1;
          w_hi       = IDX_W'(j);
        end else begin
          w_lo_found = 1'b1;
          w_lo       = IDX_W'(j);
        end
      end
    end
    w_win = w_hi_found ? w_hi : w_lo;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grnt_nxt  = r_grnt;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_nxt = S_ADDR;
          w_grnt_nxt  = NUM_M'(1) << w_win;
          w_owner_nxt = w_win;
          w_last_nxt  = w_win;
        end
      end
      S_ADDR: begin
        if (w_ar_hs) begin
          w_state_nxt = S_DATA;
          w_cnt_nxt   = bus.arlen;
        end else if (!bus.m_req[r_owner]) begin
          w_state_nxt = S_IDLE;
          w_grnt_nxt  = '0;
          w_owner_nxt = '0;
        end
      end
      S_DATA: begin
        // Requests are ignored here: only rlast (or the watchdog) ends a burst.
        if (w_r_hs) begin
          if (r_cnt != 4'd0) begin
            w_cnt_nxt = r_cnt - 4'd1;
          end
          if (bus.rlast) begin
            w_state_nxt = S_IDLE;
            w_grnt_nxt  = '0;
            w_owner_nxt = '0;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grnt_nxt  = '0;
        w_owner_nxt = '0;
      end
    endcase
    if (w_to) begin
      w_state_nxt = S_IDLE;
      w_grnt_nxt  = '0;
      w_owner_nxt = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_grnt    <= '0;
      r_owner   <= '0;
      r_last    <= IDX_W'(NUM_M - 1);
      r_cnt     <= '0;
      r_err_len <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_grnt  <= w_grnt_nxt;
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_len_err) begin
        r_err_len <= 1'b1;
      end else if (i_err_clr) begin
        r_err_len <= 1'b0;
      end
    end
  end

`ifdef AXI_RD_ARB_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0] r_wdog;
  logic            r_err_to;
  logic            w_hs;

  assign w_hs = w_ar_hs || w_r_hs;
  assign w_to = (r_state != S_IDLE) && !w_hs && (r_wdog == WD_W'(TIMEOUT_CYC));

  // Held at zero while idle, so it is already clear on entry to ADDR.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wdog   <= '0;
      r_err_to <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) || w_hs) begin
        r_wdog <= '0;
      end else if (r_wdog != WD_W'(TIMEOUT_CYC)) begin
        r_wdog <= r_wdog + 1'b1;
      end
      if (w_to) begin
        r_err_to <= 1'b1;
      end else if (i_err_clr) begin
        r_err_to <= 1'b0;
      end
    end
  end

  assign o_err_timeout = r_err_to;
`else
  assign w_to          = 1'b0;
  assign o_err_timeout = 1'b0;
`endif

  assign bus.m_grnt = r_grnt;
  assign o_busy     = (r_state != S_IDLE);
  assign o_owner    = r_owner;
  assign o_err_len  = r_err_len;

endmodule

// File: tb/tb_axi_rd_rr_arbiter.sv
// Directed bench for axi_rd_rr_arbiter with two masters; checks grant timing, round-robin order and error flags.
module tb_axi_rd_rr_arbiter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       err_clr;
  logic       busy;
  logic [0:0] owner;
  logic       err_len;
  logic       err_to;
  int         checks = 0;
  int         errors = 0;
  logic [1:0] pat [12] = '{2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00,
                           2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00};

  axi_rd_arb_if #(.NUM_M(2)) bus ();

  axi_rd_rr_arbiter #(.NUM_M(2), .IDX_W(1), .TIMEOUT_CYC(8)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .bus           (bus),
    .i_err_clr     (err_clr),
    .o_busy        (busy),
    .o_owner       (owner),
    .o_err_len     (err_len),
    .o_err_timeout (err_to)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.m_req   = 2'b00;
    bus.arvalid = 1'b0;
    bus.arready = 1'b0;
    bus.arlen   = 4'd0;
    bus.rvalid  = 1'b0;
    bus.rready  = 1'b0;
    bus.rlast   = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    err_clr = 1'b0;
    idle_bus();
    step();
    step();
    check("rst_grnt", 8'(bus.m_grnt), 8'h0);
    check("rst_busy", 8'(busy), 8'h0);
    check("rst_owner", 8'(owner), 8'h0);
    check("rst_err_len", 8'(err_len), 8'h0);
    check("rst_err_to", 8'(err_to), 8'h0);
    rst_n = 1'b1;

    // Master 0 alone, arlen=3, with one stalled rlast cycle before the real last beat
    bus.m_req = 2'b01;
    step();
    check("t1_grnt", 8'(bus.m_grnt), 8'h1);
    check("t1_busy", 8'(busy), 8'h1);
    check("t1_owner", 8'(owner), 8'h0);
    bus.arvalid = 1'b1; bus.arready = 1'b1; bus.arlen = 4'd3;
    step();
    check("t1_ar_hold", 8'(bus.m_grnt), 8'h1);
    bus.arvalid = 1'b0;
    bus.rvalid = 1'b1; bus.rready = 1'b1; bus.rlast = 1'b0;
    step();
    step();
    step();
    bus.rready = 1'b0; bus.rlast = 1'b1;
    step();
    check("t1_stall_grnt", 8'(bus.m_grnt), 8'h1);
    check("t1_stall_busy", 8'(busy), 8'h1);
    bus.rready = 1'b1;
    step();
    check("t1_rel_grnt", 8'(bus.m_grnt), 8'h0);
    check("t1_rel_busy", 8'(busy), 8'h0);
    check("t1_err_len", 8'(err_len), 8'h0);
    idle_bus();

    // Both masters requesting, single-beat bursts; master 0 won last so master 1 goes first
    bus.m_req = 2'b11;
    bus.arvalid = 1'b1; bus.arready = 1'b1; bus.arlen = 4'd0;
    bus.rvalid = 1'b1; bus.rready = 1'b1; bus.rlast = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      check($sformatf("t2_rr_%0d", i), 8'(bus.m_grnt), 8'(pat[i]));
    end
    idle_bus();
    check("t2_err_len", 8'(err_len), 8'h0);

    // Master 1 granted, drops its request before the AR handshake
    bus.m_req = 2'b10;
    step();
    check("t3_grnt", 8'(bus.m_grnt), 8'h2);
    check("t3_owner", 8'(owner), 8'h1);
    step();
    check("t3_wait_grnt", 8'(bus.m_grnt), 8'h2);
    bus.m_req = 2'b00;
    step();
    check("t3_drop_grnt", 8'(bus.m_grnt), 8'h0);
    check("t3_drop_busy", 8'(busy), 8'h0);
    check("t3_drop_owner", 8'(owner), 8'h0);

    // arlen=3 but rlast on beat 2
    bus.m_req = 2'b01;
    step();
    check("t4_grnt", 8'(bus.m_grnt), 8'h1);
    bus.arvalid = 1'b1; bus.arready = 1'b1; bus.arlen = 4'd3;
    step();
    bus.arvalid = 1'b0;
    bus.rvalid = 1'b1; bus.rready = 1'b1; bus.rlast = 1'b0;
    step();
    check("t4_beat1_err", 8'(err_len), 8'h0);
    bus.rlast = 1'b1;
    step();
    check("t4_short_err", 8'(err_len), 8'h1);
    check("t4_short_grnt", 8'(bus.m_grnt), 8'h0);
    check("t4_short_busy", 8'(busy), 8'h0);
    idle_bus();
    err_clr = 1'b1;
    step();
    check("t4_clr", 8'(err_len), 8'h0);
    err_clr = 1'b0;

    // arlen=0 with a non-last beat: error set wins over clear, counter saturates at 0
    bus.m_req = 2'b01;
    step();
    check("t5_grnt", 8'(bus.m_grnt), 8'h1);
    bus.arvalid = 1'b1; bus.arready = 1'b1; bus.arlen = 4'd0;
    step();
    bus.arvalid = 1'b0;
    bus.rvalid = 1'b1; bus.rready = 1'b1; bus.rlast = 1'b0;
    err_clr = 1'b1;
    step();
    check("t5_set_wins", 8'(err_len), 8'h1);
    check("t5_hold_grnt", 8'(bus.m_grnt), 8'h1);
    bus.rlast = 1'b1;
    step();
    check("t5_sat_clr", 8'(err_len), 8'h0);
    check("t5_rel_grnt", 8'(bus.m_grnt), 8'h0);
    idle_bus();
    err_clr = 1'b0;

    // Reset during data beat 2 of 4
    bus.m_req = 2'b11;
    step();
    check("t6_grnt", 8'(bus.m_grnt), 8'h2);
    bus.arvalid = 1'b1; bus.arready = 1'b1; bus.arlen = 4'd3;
    step();
    bus.arvalid = 1'b0;
    bus.rvalid = 1'b1; bus.rready = 1'b1; bus.rlast = 1'b0;
    step();
    check("t6_data_busy", 8'(busy), 8'h1);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_rst_grnt", 8'(bus.m_grnt), 8'h0);
    check("t6_rst_busy", 8'(busy), 8'h0);
    check("t6_rst_owner", 8'(owner), 8'h0);
    idle_bus();
    bus.m_req = 2'b11;
    step();
    rst_n = 1'b1;
    step();
    check("t6_after_grnt", 8'(bus.m_grnt), 8'h1);
    check("t6_after_owner", 8'(owner), 8'h0);
    idle_bus();
    step();

`ifdef AXI_RD_ARB_TIMEOUT_EN
    // Slave never returns data after the AR handshake
    bus.m_req = 2'b01;
    step();
    bus.arvalid = 1'b1; bus.arready = 1'b1; bus.arlen = 4'd0;
    step();
    bus.arvalid = 1'b0;
    repeat (8) step();
    check("to_hold_grnt", 8'(bus.m_grnt), 8'h1);
    check("to_hold_err", 8'(err_to), 8'h0);
    step();
    check("to_fire_grnt", 8'(bus.m_grnt), 8'h0);
    check("to_fire_err", 8'(err_to), 8'h1);
    idle_bus();
    err_clr = 1'b1;
    step();
    check("to_clr", 8'(err_to), 8'h0);
    err_clr = 1'b0;
`else
    check("to_absent", 8'(err_to), 8'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi_rd_rr_arbiter.md
Name: axi_rd_rr_arbiter

Overview:
- Round-robin grant controller for the shared AXI read channel used by the cache load masters (I-cache, D-cache, uncached loads).
- Owns the master grant vector and holds each grant for one complete AR + R burst transaction.
- Observes the post-mux shared AR/R handshake signals; the downstream master mux steers the channel from the one-hot grant.
- Also flags burst-length protocol errors on the shared channel.

Parameters:
- NUM_M, 2: number of requesting masters (2..8).
- IDX_W, 1: width of the owner index; must equal ceil(log2(NUM_M)), minimum 1.
- TIMEOUT_CYC, 1023: maximum idle cycles in ADDR/DATA before forced release (used only with the optional feature).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- m_req  in  NUM_M  per-master request; level, held by the master until its burst completes.
- m_grnt  out  NUM_M  one-hot grant, registered.
- arvalid  in  1  shared AR valid (after mux).
- arready  in  1  shared AR ready from slave.
- arlen  in  4  shared AR burst length (beats-1).
- rvalid  in  1  shared R valid from slave.
- rready  in  1  shared R ready (after mux).
- rlast  in  1  shared R last.
- busy  out  1  high in ADDR or DATA.
- owner  out  IDX_W  index of the granted master; 0 when idle.
- err_len  out  1  sticky: rlast/beat-count mismatch seen.
- err_timeout  out  1  sticky: forced release (always 0 when the optional feature is absent).
- err_clr  in  1  synchronous clear of both sticky error bits.

Behaviour:
- Reset values:
  - m_grnt=0, busy=0, owner=0, err_len=0, err_timeout=0.
  - Internal: state=IDLE, beat counter=0, last winner=NUM_M-1, so master 0 wins first.
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - If m_req!=0, select the first requester searching upward from (last winner+1) mod NUM_M, wrapping around.
  - Next cycle: m_grnt=onehot(winner), owner=winner, last winner updated, state=ADDR.
  - Request-to-grant latency is 1 cycle.
  - With no request, stay in IDLE.
- ADDR:
  - On arvalid&&arready: load beat counter with arlen, then go to DATA.
  - If the owner's m_req drops before the AR handshake: release the grant next cycle and return to IDLE (last winner still updated).
- DATA:
  - Each rvalid&&rready beat: counter decrements; saturates at 0.
  - A beat with rlast=1: m_grnt=0 and state=IDLE on the next edge.
    - One dead cycle follows before any re-grant (new grant appears 2 cycles after the rlast beat).
  - If rlast occurs with counter!=0, or a beat arrives with counter==0 and rlast=0: set err_len; state transitions still follow rlast only.
  - m_req is ignored in DATA; a burst is never aborted by the master.
- Grant changes:
  - Only on state transitions; the grant is never switched mid-transaction.
  - m_grnt is always one-hot or zero.
- Simultaneous requests: round-robin order applies. Example with NUM_M=2 and both requesting continuously: grants alternate 0,1,0,1.
- err_clr:
  - Clears sticky bits the next cycle.
  - If a set condition occurs in the same cycle, set wins.
- Reset mid-transaction: all outputs return to reset values immediately (asynchronous); the outstanding burst is abandoned.
- Beat counter width is 4 bits; arlen=15 means 16 beats.

Optional Feature:
- Macro: AXI_RD_ARB_TIMEOUT_EN.
- When defined:
  - A watchdog counter resets on entry to ADDR and on every AR or R handshake, and increments otherwise while busy.
  - When it reaches TIMEOUT_CYC: set err_timeout, deassert m_grnt, go to IDLE next cycle.
  - Counter width is ceil(log2(TIMEOUT_CYC+1)).
- When undefined: no watchdog logic; err_timeout is tied to 0; a hung slave holds the grant indefinitely.

Test Plan:
- Master 0 alone, req at cycle 0, arlen=3, 4 beats with rlast on beat 4: m_grnt=01 at cycle 1; released the cycle after beat 4; err_len=0.
- NUM_M=2, both masters requesting continuously with arlen=0: grants alternate 01,10,01,10 with 1 dead cycle between bursts.
- Master 1 requests, AR not yet issued, then drops req: m_grnt returns to 00 next cycle; busy=0.
- arlen=3 but rlast on beat 2: err_len=1 and grant released; err_clr pulse gives err_len=0 the next cycle.
- Reset asserted during DATA beat 2 of 4: m_grnt=0, busy=0 immediately; after release, master 0 wins first.
- With AXI_RD_ARB_TIMEOUT_EN and TIMEOUT_CYC=8: no rvalid after the AR handshake gives err_timeout=1 and grant dropped after 8 idle cycles.
